// File: rtl/tsp_city_loader.sv
// tsp_city_loader: byte-stream loader for the TSP solver's city coordinate
// tables. The frame is 0xA5, then interleaved x/y bytes per city, then an
// optional XOR checksum. Bytes are captured into shadow registers, and a
// complete frame is committed to xs/ys in one cycle, followed by a solver
// restart pulse.
//
// Build option: define TSP_LOADER_CHECKSUM_EN to enable the trailing checksum
// byte, the CHECK state and the rejected-frame counter. Without it, a frame
// commits right after its last y byte and err_cnt is tied to zero.
//
// state  | meaning
// IDLE   | hunting for the 0xA5 header; other bytes are discarded
// RX_X   | next byte is x of city idx
// RX_Y   | next byte is y of city idx
// CHECK  | next byte is the XOR checksum (checksum build only)
// COMMIT | one cycle: shadow -> xs/ys, in_ready low
module tsp_city_loader #(
  parameter int N_CITIES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       abort,
  output logic [7:0] xs [N_CITIES-1:0],
  output logic [7:0] ys [N_CITIES-1:0],
  output logic       loaded,
  output logic       solver_rst,
  output logic [7:0] err_cnt
);

  localparam int IW = $clog2(N_CITIES);
  localparam logic [IW-1:0] LAST = IW'(N_CITIES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RX_X,
    RX_Y,
`ifdef TSP_LOADER_CHECKSUM_EN
    CHECK,
`endif
    COMMIT
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [7:0]    shadow_x [N_CITIES-1:0];
  logic [7:0]    shadow_y [N_CITIES-1:0];
  logic          accept;
  logic          take;

`ifdef TSP_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign in_ready = !rst && (state != COMMIT);
  assign accept   = in_valid && in_ready;
  // abort wins over a byte arriving in the same cycle, so that byte is dropped
  assign take     = accept && !abort;

  // Next-state decode; COMMIT always completes, even if abort is raised
  always_comb begin
    state_nxt = state;
    if (state == COMMIT) begin
      state_nxt = IDLE;
    end else if (abort) begin
      state_nxt = IDLE;
    end else if (accept) begin
      case (state)
        IDLE: if (in_data == 8'hA5) state_nxt = RX_X;
        RX_X: state_nxt = RX_Y;
        RX_Y: begin
          if (idx == LAST) begin
`ifdef TSP_LOADER_CHECKSUM_EN
            state_nxt = CHECK;
`else
            state_nxt = COMMIT;
`endif
          end else begin
            state_nxt = RX_X;
          end
        end
`ifdef TSP_LOADER_CHECKSUM_EN
        CHECK: state_nxt = (in_data == csum) ? COMMIT : IDLE;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // City index and running checksum; the header byte is not part of csum
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
`ifdef TSP_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else if (take) begin
      case (state)
        IDLE: begin
          if (in_data == 8'hA5) begin
            idx <= '0;
`ifdef TSP_LOADER_CHECKSUM_EN
            csum <= '0;
`endif
          end
        end
        RX_X: begin
`ifdef TSP_LOADER_CHECKSUM_EN
          csum <= csum ^ in_data;
`endif
        end
        RX_Y: begin
`ifdef TSP_LOADER_CHECKSUM_EN
          csum <= csum ^ in_data;
`endif
          if (idx != LAST) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Shadow capture; contents are don't-care until a full frame has landed
  always_ff @(posedge clk) begin
    if (take && state == RX_X) shadow_x[idx] <= in_data;
    if (take && state == RX_Y) shadow_y[idx] <= in_data;
  end

  // Atomic commit of the shadow tables, then a one-cycle solver restart
  always_ff @(posedge clk) begin
    if (rst) begin
      xs         <= '{default: '0};
      ys         <= '{default: '0};
      loaded     <= 1'b0;
      solver_rst <= 1'b0;
    end else begin
      solver_rst <= (state == COMMIT);
      if (state == COMMIT) begin
        xs     <= shadow_x;
        ys     <= shadow_y;
        loaded <= 1'b1;
      end
    end
  end

`ifdef TSP_LOADER_CHECKSUM_EN
  // Saturating count of frames rejected on checksum mismatch
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (take && state == CHECK && in_data != csum && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_tsp_city_loader.sv
// Self-checking bench for tsp_city_loader. Expected committed tables are
// queued when a frame is sent and compared when solver_rst pulses.
// Follows TSP_LOADER_CHECKSUM_EN the same way the design does.
module tb_tsp_city_loader;
  localparam int N = 64;

  typedef struct packed {
    logic [N-1:0][7:0] xv;
    logic [N-1:0][7:0] yv;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'hA5;
  logic       in_valid = 1'b1;
  logic       in_ready;
  logic       abort = 1'b0;
  logic [7:0] xs [N-1:0];
  logic [7:0] ys [N-1:0];
  logic       loaded;
  logic       solver_rst;
  logic [7:0] err_cnt;

  int     errors = 0;
  int     checks = 0;
  int     commits = 0;
  int     exp_err = 0;
  frame_t exp_q[$];
  frame_t last_f;

  always #5 clk = ~clk;

  tsp_city_loader #(.N_CITIES(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .xs(xs), .ys(ys),
    .loaded(loaded), .solver_rst(solver_rst), .err_cnt(err_cnt)
  );

  // Scoreboard: every restart pulse must match the oldest queued frame
  always @(negedge clk) begin : monitor
    frame_t e;
    int bad;
    if (!rst && solver_rst) begin
      commits++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: solver_rst=1 with no frame expected");
      end else begin
        e = exp_q.pop_front();
        bad = -1;
        for (int i = 0; i < N; i++)
          if (xs[i] !== e.xv[i] || ys[i] !== e.yv[i]) bad = i;
        if (bad >= 0) begin
          errors++;
          $display("FAIL commit_data: city %0d got x=%h y=%h expected x=%h y=%h",
                   bad, xs[bad], ys[bad], e.xv[bad], e.yv[bad]);
        end
        last_f = e;
      end
      checks++;
      if (loaded !== 1'b1) begin
        errors++;
        $display("FAIL commit_loaded: got %b expected 1", loaded);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  function automatic frame_t ramp_frame();
    frame_t f;
    for (int i = 0; i < N; i++) begin
      f.xv[i] = 8'(i);
      f.yv[i] = 8'(255 - i);
    end
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < N; i++) begin
      f.xv[i] = 8'($urandom);
      f.yv[i] = 8'($urandom);
    end
    return f;
  endfunction

  function automatic logic [7:0] calc_csum(input frame_t f);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < N; i++) c = c ^ f.xv[i] ^ f.yv[i];
    return c;
  endfunction

  function automatic int bub(input int m);
    return (m > 0) ? int'($urandom_range(m, 0)) : 0;
  endfunction

  // Drive one byte (entered and left at posedge+1) and wait for its acceptance
  task automatic send_byte(input logic [7:0] b, input int bubbles);
    int n;
    if (bubbles > 0) begin
      in_valid = 1'b0;
      repeat (bubbles) @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input frame_t f, input bit bad_ck, input bit expect_commit,
                            input int max_bub, input bit abort_commit,
                            input bit tail, input bit skip_hdr);
    logic [7:0] ck;
    ck = calc_csum(f) ^ {7'b0, bad_ck};
    if (expect_commit) exp_q.push_back(f);
    if (!skip_hdr) send_byte(8'hA5, bub(max_bub));
    for (int i = 0; i < N; i++) begin
      send_byte(f.xv[i], bub(max_bub));
      send_byte(f.yv[i], bub(max_bub));
    end
`ifdef TSP_LOADER_CHECKSUM_EN
    send_byte(ck, bub(max_bub));
`endif
    if (tail) begin
      in_valid = 1'b0;
      if (abort_commit) abort = 1'b1;
      @(negedge clk);
      checks++;
      if (solver_rst !== 1'b0) begin
        errors++;
        $display("FAIL pulse_early: solver_rst=%b expected 0", solver_rst);
      end
      checks++;
      if (in_ready !== !expect_commit) begin
        errors++;
        $display("FAIL commit_ready: in_ready=%b expected %b", in_ready, !expect_commit);
      end
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      checks++;
      if (solver_rst !== expect_commit) begin
        errors++;
        $display("FAIL pulse_edge: solver_rst=%b expected %b", solver_rst, expect_commit);
      end
      @(negedge clk);
      checks++;
      if (solver_rst !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width: solver_rst=%b expected 0", solver_rst);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready: cycle %0d got %b expected 0", c, in_ready);
      end
      checks++;
      if ({loaded, solver_rst, err_cnt, xs[0], ys[N-1]} !== 26'd0) begin
        errors++;
        $display("FAIL reset_outputs: loaded=%b solver_rst=%b err_cnt=%h xs0=%h ys63=%h expected all 0",
                 loaded, solver_rst, err_cnt, xs[0], ys[N-1]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame();
    send_frame(ramp_frame(), 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (xs[5] !== 8'd5 || ys[5] !== 8'd250 || xs[63] !== 8'd63) begin
      errors++;
      $display("FAIL good_values: xs5=%0d ys5=%0d xs63=%0d expected 5 250 63", xs[5], ys[5], xs[63]);
    end
    checks++;
    if (loaded !== 1'b1) begin
      errors++;
      $display("FAIL good_loaded: got %b expected 1", loaded);
    end
  endtask

  task automatic test_framing();
    frame_t f;
    int c0;
    c0 = commits;
    send_byte(8'h00, 0);
    send_byte(8'h13, 1);
    send_byte(8'h5A, 2);
    f = rand_frame();
    f.xv[7] = 8'hA5;
    f.yv[3] = 8'hA5;
    send_frame(f, 1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0);
    checks++;
    if (commits - c0 !== 1) begin
      errors++;
      $display("FAIL framing_commits: got %0d expected 1", commits - c0);
    end
    checks++;
    if (xs[7] !== 8'hA5 || ys[3] !== 8'hA5) begin
      errors++;
      $display("FAIL framing_a5_data: xs7=%h ys3=%h expected a5 a5", xs[7], ys[3]);
    end
  endtask

  task automatic test_abort();
    frame_t f;
    f = rand_frame();
    send_byte(8'hA5, 0);
    for (int i = 0; i < 5; i++) begin
      send_byte(f.xv[i], 0);
      send_byte(f.yv[i], 0);
    end
    in_data  = f.xv[5];
    in_valid = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    send_frame(rand_frame(), 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (err_cnt !== 8'(exp_err)) begin
      errors++;
      $display("FAIL abort_err_cnt: got %0d expected %0d", err_cnt, exp_err);
    end
    send_frame(rand_frame(), 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_frame(rand_frame(), 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_commit_ready: got %b expected 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || solver_rst !== 1'b1) begin
      errors++;
      $display("FAIL b2b_after_commit: in_ready=%b solver_rst=%b expected 1 1", in_ready, solver_rst);
    end
    @(posedge clk);
    #1;
    send_frame(rand_frame(), 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_checksum();
`ifdef TSP_LOADER_CHECKSUM_EN
    frame_t f;
    f = ramp_frame();
    f.xv[0] = 8'h77;
    send_frame(f, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    exp_err++;
    checks++;
    if (err_cnt !== 8'(exp_err)) begin
      errors++;
      $display("FAIL bad_ck_err_cnt: got %0d expected %0d", err_cnt, exp_err);
    end
    checks++;
    if (xs[0] !== last_f.xv[0] || ys[5] !== last_f.yv[5]) begin
      errors++;
      $display("FAIL bad_ck_hold: xs0=%h ys5=%h expected %h %h", xs[0], ys[5], last_f.xv[0], last_f.yv[5]);
    end
    for (int k = 0; k < 256; k++) begin
      send_frame(rand_frame(), 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      if (exp_err < 255) exp_err++;
    end
    checks++;
    if (err_cnt !== 8'(exp_err)) begin
      errors++;
      $display("FAIL err_cnt_saturate: got %0d expected %0d", err_cnt, exp_err);
    end
`else
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL err_cnt_tied: got %0d expected 0", err_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_framing();
    test_abort();
    test_back_to_back();
    test_checksum();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_commits: %0d frames never committed, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
